comparator_4bit: RTL and testbench

- Parameterised magnitude comparator; default 4-bit operands A and B.
- Produces one-hot registered flags: AeB (A equal to B), AgB (A greater than B), AlB (A less than B).
- Provides 7485-style cascade inputs so several instances can be chained into wider comparators.
- Sits in datapath control logic wherever an operand-ordering decision is needed one cycle after the operands are presented.

---
 rtl/comparator_4bit.sv | 69 ++++++
 tb/tb_comparator_4bit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/comparator_4bit.sv
// Registered magnitude comparator with 7485-style cascade inputs.
// One result per in_valid cycle, presented on the flags one clock later.
module comparator_4bit #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             casc_eq,
  input  logic             casc_gt,
  input  logic             casc_lt,
  output logic             out_valid,
  output logic             AeB,
  output logic             AgB,
  output logic             AlB
);

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  // Flag vector layout: {gt, eq, lt}.
  logic [2:0] flags_d, flags_q;
  logic       vld_d, vld_q;

  function automatic logic [2:0] resolve(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             ceq,
    input logic             cgt,
    input logic             clt
  );
    logic [2:0] r;
    if (a > b)       r = 3'b100;
    else if (a < b)  r = 3'b001;
    else if (ceq)    r = 3'b010;
    else if (cgt)    r = 3'b100;
    else if (clt)    r = 3'b001;
    else             r = 3'b010;
    return r;
  endfunction

  always_comb begin
    flags_d = flags_q;
    vld_d   = in_valid;
    if (in_valid) begin
      flags_d = resolve(A ^ SIGN_MASK, B ^ SIGN_MASK, casc_eq, casc_gt, casc_lt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 3'b000;
      vld_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign AgB       = flags_q[2];
  assign AeB       = flags_q[1];
  assign AlB       = flags_q[0];

endmodule

// File: tb/tb_comparator_4bit.sv
// Directed self-checking bench for comparator_4bit, unsigned and signed builds.
// Observed values are packed as {out_valid, AgB, AeB, AlB}.
module tb_comparator_4bit;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] GT   = 4'b1100;
  localparam logic [3:0] EQ   = 4'b1010;
  localparam logic [3:0] LT   = 4'b1001;
  localparam logic [3:0] H_GT = 4'b0100;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] A, B, A_s, B_s;
  logic       casc_eq, casc_gt, casc_lt;
  logic       vu, gu, eu, lu;
  logic       vs, gs, es, ls;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
    .casc_eq(casc_eq), .casc_gt(casc_gt), .casc_lt(casc_lt),
    .out_valid(vu), .AeB(eu), .AgB(gu), .AlB(lu)
  );

  comparator_4bit #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A_s), .B(B_s),
    .casc_eq(casc_eq), .casc_gt(casc_gt), .casc_lt(casc_lt),
    .out_valid(vs), .AeB(es), .AgB(gs), .AlB(ls)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_u(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return GT;
    if (a < b) return LT;
    return EQ;
  endfunction

  initial begin
    logic [3:0] ra, rb;
    rst = 1'b1; in_valid = 1'b1; A = 4'd5; B = 4'd3;
    A_s = 4'd0; B_s = 4'd0;
    casc_eq = 1'b1; casc_gt = 1'b0; casc_lt = 1'b0;

    // Reset held across two edges with valid inputs present.
    step(); chk("rst_e1", {vu, gu, eu, lu}, NONE);
    step(); chk("rst_e2", {vu, gu, eu, lu}, NONE);
    rst = 1'b0;
    step(); chk("first_cap", {vu, gu, eu, lu}, GT);

    // Directed unsigned vectors, one per cycle.
    A = 4'b1010; B = 4'b0011; step(); chk("u_gt", {vu, gu, eu, lu}, GT);
    A = 4'b0001; B = 4'b1111; step(); chk("u_lt", {vu, gu, eu, lu}, LT);
    A = 4'b0110; B = 4'b0110; step(); chk("u_eq", {vu, gu, eu, lu}, EQ);
    A = 4'b0000; B = 4'b1111; step(); chk("u_0v15", {vu, gu, eu, lu}, LT);
    A = 4'b1111; B = 4'b0000; step(); chk("u_15v0", {vu, gu, eu, lu}, GT);
    A = 4'b1111; B = 4'b1111; step(); chk("u_15v15", {vu, gu, eu, lu}, EQ);

    // Random pairs against the reference model.
    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      A = ra; B = rb;
      step();
      chk($sformatf("rand%0d", i), {vu, gu, eu, lu}, ref_u(ra, rb));
    end

    // Hold: flags keep the last result while operands move.
    A = 4'd9; B = 4'd2; step(); chk("hold_load", {vu, gu, eu, lu}, GT);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      A = 4'(i); B = 4'(15 - i);
      step();
      chk($sformatf("hold%0d", i), {vu, gu, eu, lu}, H_GT);
    end
    in_valid = 1'b1;

    // Cascade priority with equal operands.
    A = 4'b0111; B = 4'b0111;
    casc_eq = 1'b0; casc_gt = 1'b1; casc_lt = 1'b0; step(); chk("c_gt", {vu, gu, eu, lu}, GT);
    casc_eq = 1'b0; casc_gt = 1'b0; casc_lt = 1'b1; step(); chk("c_lt", {vu, gu, eu, lu}, LT);
    casc_eq = 1'b0; casc_gt = 1'b0; casc_lt = 1'b0; step(); chk("c_none", {vu, gu, eu, lu}, EQ);
    casc_eq = 1'b1; casc_gt = 1'b1; casc_lt = 1'b0; step(); chk("c_eqgt", {vu, gu, eu, lu}, EQ);
    // Cascade is ignored when operands differ.
    A = 4'b0010; B = 4'b0111;
    casc_eq = 1'b0; casc_gt = 1'b1; step(); chk("c_ign", {vu, gu, eu, lu}, LT);
    casc_eq = 1'b1; casc_gt = 1'b0;

    // Signed instance, compared alongside the unsigned one on the same bits.
    A = 4'b1000; B = 4'b0111; A_s = 4'b1000; B_s = 4'b0111; step();
    chk("s_m8v7", {vs, gs, es, ls}, LT);
    chk("u_8v7", {vu, gu, eu, lu}, GT);
    A_s = 4'b1111; B_s = 4'b1110; step(); chk("s_m1vm2", {vs, gs, es, ls}, GT);
    A_s = 4'b0111; B_s = 4'b1000; step(); chk("s_7vm8", {vs, gs, es, ls}, GT);
    A_s = 4'b1001; B_s = 4'b1001; step(); chk("s_eq", {vs, gs, es, ls}, EQ);

    // Asynchronous reset between edges while AgB is set.
    A = 4'd12; B = 4'd4; step(); chk("pre_arst", {vu, gu, eu, lu}, GT);
    #2 rst = 1'b1;
    #1 chk("arst_u", {vu, gu, eu, lu}, NONE);
    chk("arst_s", {vs, gs, es, ls}, NONE);
    step(); chk("arst_hold", {vu, gu, eu, lu}, NONE);
    #2 rst = 1'b0;
    A = 4'd3; B = 4'd11; step(); chk("post_arst", {vu, gu, eu, lu}, LT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
